// File: rtl/pipe_stage_elastic_pkg.sv
// pipe_stage_elastic_pkg: occupancy state encoding and per-boundary control widths/bubbles
package pipe_stage_elastic_pkg;

    // Encoding doubles as the occupancy count driven on level.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } ps_state_t;

    localparam int IF_ID_CTRL_W  = 16;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int EX_MEM_CTRL_W = 16;
    localparam int MEM_WB_CTRL_W = 16;

    localparam logic [15:0] IF_ID_BUBBLE  = 16'h0000;
    localparam logic [15:0] ID_EX_BUBBLE  = 16'h0000;
    localparam logic [15:0] EX_MEM_BUBBLE = 16'h0000;
    localparam logic [15:0] MEM_WB_BUBBLE = 16'h0000;

    function automatic logic [1:0] level_of(ps_state_t s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// pipe_stage_elastic_if: handshake, data/control bundles and stall/flush controls of one stage
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
);
    logic              busywait;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        level;

    modport master (
        output busywait, flush, in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, level
    );

    modport slave (
        input  busywait, flush, in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, level
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline register with optional 2-entry skid buffer,
// global stall, flush and bubbling of the control bundle while empty
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter bit                SKID_EN     = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    pipe_stage_elastic_if.slave bus
);
    ps_state_t         state, state_n;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              rdy_q, accept, emit, load_in, load_from_skid;

    // rdy_q is the registered "not full" flag; without skid the stage may also
    // take a new entry in the same cycle the held one leaves.
    assign bus.in_ready   = rdy_q & (SKID_EN | (state == PS_EMPTY) | (bus.out_ready & ~bus.busywait));
    assign accept         = bus.in_valid & bus.in_ready & ~bus.busywait & ~bus.flush;
    assign emit           = bus.out_valid & bus.out_ready & ~bus.busywait;
    assign load_in        = accept & ((state == PS_EMPTY) | emit);
    assign load_from_skid = emit & (state == PS_TWO) & ~bus.flush;

    always_comb begin
        state_n = state;
        case (state)
            PS_EMPTY: state_n = accept ? PS_ONE : PS_EMPTY;
            PS_ONE:   state_n = accept ? (emit ? PS_ONE : PS_TWO) : (emit ? PS_EMPTY : PS_ONE);
            PS_TWO:   state_n = emit ? PS_ONE : PS_TWO;
            default:  state_n = PS_EMPTY;
        endcase
        if (bus.flush) state_n = PS_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PS_EMPTY;
            rdy_q     <= 1'b0;
            main_data <= '0;
            main_ctrl <= '0;
        end else begin
            state <= state_n;
            rdy_q <= state_n != PS_TWO;
            if (load_in) begin
                main_data <= bus.in_data;
                main_ctrl <= bus.in_ctrl;
            end else if (load_from_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic load_skid;
            assign load_skid = accept & (state == PS_ONE) & ~emit;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_data <= '0;
                    skid_ctrl <= '0;
                end else if (load_skid) begin
                    skid_data <= bus.in_data;
                    skid_ctrl <= bus.in_ctrl;
                end
            end
        end else begin : g_no_skid
            assign skid_data = '0;
            assign skid_ctrl = '0;
        end
    endgenerate

    // Control is masked so downstream never sees stale enables on a bubble.
    assign bus.out_valid = state != PS_EMPTY;
    assign bus.out_data  = main_data;
    assign bus.out_ctrl  = bus.out_valid ? main_ctrl : BUBBLE_CTRL;
    assign bus.level     = level_of(state);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: skid and no-skid builds driven by shared stimulus, each checked
// by a queue scoreboard (push on accept, compare/pop on emit, clear on flush/reset)
module tb_pipe_stage_elastic;
    localparam int              DW  = 32;
    localparam int              CW  = 16;
    localparam logic [CW-1:0]   BUB = 16'h5A5A;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic up;
    int   cmp = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) i0 ();
    pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) i1 ();

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID_EN(1'b1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID_EN(1'b0))
        u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

    logic          ov[2], ir[2];
    logic [1:0]    lv[2];
    logic [DW-1:0] od[2];
    logic [CW-1:0] oc[2];

    assign ov[0] = i0.out_valid; assign ov[1] = i1.out_valid;
    assign ir[0] = i0.in_ready;  assign ir[1] = i1.in_ready;
    assign lv[0] = i0.level;     assign lv[1] = i1.level;
    assign od[0] = i0.out_data;  assign od[1] = i1.out_data;
    assign oc[0] = i0.out_ctrl;  assign oc[1] = i1.out_ctrl;

    // Stage may accept only from the first edge after reset release.
    always @(posedge clk or negedge rst_n) up <= rst_n;

    task automatic chk(string n, logic [47:0] a, logic [47:0] e);
        cmp++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic put(logic iv, logic [DW-1:0] d, logic [CW-1:0] c, logic ordy, logic bw, logic fl);
        i0.in_valid = iv; i1.in_valid = iv;
        i0.in_data = d; i1.in_data = d;
        i0.in_ctrl = c; i1.in_ctrl = c;
        i0.out_ready = ordy; i1.out_ready = ordy;
        i0.busywait = bw; i1.busywait = bw;
        i0.flush = fl; i1.flush = fl;
    endtask

    task automatic drv(logic iv, logic [DW-1:0] d, logic [CW-1:0] c, logic ordy, logic bw, logic fl);
        put(iv, d, c, ordy, bw, fl);
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : sb
        ent_t q[$];
        logic a;
        ent_t e;

        // Stimulus side: record what the stage took this cycle, commit at the edge.
        always begin
            @(negedge clk);
            a = i0.in_valid && ir[g] && !i0.busywait && !i0.flush;
            e = '{d: i0.in_data, c: i0.in_ctrl};
            @(posedge clk);
            if (rst_n && a) q.push_back(e);
        end

        always @(negedge rst_n) q.delete();

        // Monitor: compare visible state against the queue, then retire.
        always @(negedge clk) begin
            int  n;
            logic exp_rdy;
            if (rst_n) begin
                n = q.size();
                exp_rdy = up && ((g == 0) ? (n < 2) : (n == 0 || (i0.out_ready && !i0.busywait)));
                chk($sformatf("u%0d.level", g), 48'(lv[g]), 48'(n));
                chk($sformatf("u%0d.out_valid", g), 48'(ov[g]), 48'(n > 0));
                chk($sformatf("u%0d.in_ready", g), 48'(ir[g]), 48'(exp_rdy));
                chk($sformatf("u%0d.out_ctrl", g), 48'(oc[g]), 48'((n > 0) ? q[0].c : BUB));
                if (n > 0) chk($sformatf("u%0d.out_data", g), 48'(od[g]), 48'(q[0].d));
                if (i0.flush) q.delete();
                else if (n > 0 && i0.out_ready && !i0.busywait) void'(q.pop_front());
            end
        end
    end

    initial begin
        put(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drv(0, 0, 0, 1, 0, 0);
        // streaming 0x00..0x07
        for (int i = 0; i < 8; i++) drv(1, DW'(i), CW'(16'h0100 + i), 1, 0, 0);
        repeat (2) drv(0, 0, 0, 1, 0, 0);
        // backpressure on 0xA1
        drv(1, 32'hA0, 16'h0011, 1, 0, 0);
        drv(1, 32'hA1, 16'h0012, 0, 0, 0);
        drv(1, 32'hA2, 16'h0013, 0, 0, 0);
        drv(1, 32'hA2, 16'h0013, 1, 0, 0);
        drv(1, 32'hA2, 16'h0013, 1, 0, 0);
        repeat (3) drv(0, 0, 0, 1, 0, 0);
        // busywait freezes a full stage
        drv(1, 32'hB0, 16'h0021, 0, 0, 0);
        drv(1, 32'hB1, 16'h0022, 0, 0, 0);
        repeat (3) drv(1, 32'hB2, 16'h0023, 1, 1, 0);
        // flush a full stage with a same-cycle input carrying all-ones control
        drv(1, 32'hC0, 16'h0031, 0, 0, 0);
        drv(1, 32'hDEAD, 16'hFFFF, 1, 0, 1);
        repeat (3) drv(0, 0, 0, 1, 0, 0);
        // random traffic
        for (int i = 0; i < 600; i++)
            drv($urandom_range(0, 3) != 0, $urandom, CW'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
        // asynchronous reset while full
        drv(1, 32'hE0, 16'h0041, 0, 0, 0);
        drv(1, 32'hE1, 16'h0042, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("u0.rst_out_valid", 48'(ov[0]), 48'(0));
        chk("u0.rst_out_ctrl", 48'(oc[0]), 48'(BUB));
        chk("u0.rst_level", 48'(lv[0]), 48'(0));
        chk("u0.rst_in_ready", 48'(ir[0]), 48'(0));
        chk("u0.rst_out_data", 48'(od[0]), 48'(0));
        chk("u1.rst_out_valid", 48'(ov[1]), 48'(0));
        chk("u1.rst_level", 48'(lv[1]), 48'(0));
        chk("u1.rst_in_ready", 48'(ir[1]), 48'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        drv(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drv(1, DW'(32'hF0 + i), CW'(i), 1, 0, 0);
        repeat (3) drv(0, 0, 0, 1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
